button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEB_CNT, default 2_500_000, meaning the number of stable cycles required to accept a press or release (25 ms at 100 MHz).
REQ-002 SHALL have parameter RPT_DELAY, default 50_000_000, meaning the number of cycles from the press pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter RPT_PERIOD, default 10_000_000, meaning the number of cycles between successive auto-repeat pulses.
REQ-004 SHALL have port ClkPort, input, 1 bit: 100 MHz system clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port Btn, input, 1 bit: raw pushbutton, asynchronous to ClkPort, bouncing, active-high.
REQ-007 SHALL have port DPB, output, 1 bit: debounced button level.
REQ-008 SHALL have port SCEN, output, 1 bit: single-cycle pulse, once per accepted press.
REQ-009 SHALL have port MCEN, output, 1 bit: single-cycle pulse on an accepted press, then auto-repeat pulses while the button is held.
REQ-010 SHALL have port CCEN, output, 1 bit: high every cycle while the button is in the accepted-held condition.

Function
REQ-011 SHALL pass Btn through a 2-flop synchronizer; all logic uses only the synchronized value (btn_s).
REQ-012 SHALL implement an FSM with states IDLE, WQ_PRESS, PRESS_PULSE, HOLD, RPT_PULSE, RPT_WAIT and WQ_REL, sharing one counter sized for max(DEB_CNT, RPT_DELAY, RPT_PERIOD).
REQ-013 In IDLE, btn_s=1 SHALL move the FSM to WQ_PRESS with the counter cleared.
REQ-014 In WQ_PRESS, btn_s=0 SHALL return the FSM to IDLE; after DEB_CNT consecutive btn_s=1 cycles, the FSM SHALL move to PRESS_PULSE.
REQ-015 With a clean input, SCEN SHALL be high in exactly the cycle following the (DEB_CNT+2)th rising edge counted from the first edge that samples Btn high.
REQ-016 PRESS_PULSE SHALL last exactly 1 cycle, with SCEN=1 and MCEN=1, and then move to HOLD.
REQ-017 In HOLD and RPT_WAIT, btn_s=0 SHALL move the FSM to WQ_REL with the counter cleared, taking priority over any repeat due that cycle.
REQ-018 The first RPT_PULSE SHALL occur exactly RPT_DELAY cycles after the PRESS_PULSE cycle; subsequent RPT_PULSEs SHALL be spaced exactly RPT_PERIOD cycles apart.
REQ-019 RPT_PULSE SHALL last 1 cycle with MCEN=1 and SCEN=0.
REQ-020 In WQ_REL, btn_s=1 SHALL clear the counter while the FSM stays in WQ_REL.
REQ-021 In WQ_REL, after DEB_CNT consecutive btn_s=0 cycles, the FSM SHALL move to IDLE.
REQ-022 WQ_REL SHALL never emit SCEN or MCEN, so a re-press before release is accepted produces no pulse.
REQ-023 DPB SHALL be 1 in PRESS_PULSE, HOLD, RPT_PULSE, RPT_WAIT and WQ_REL, and 0 otherwise.
REQ-024 CCEN SHALL be 1 in PRESS_PULSE, HOLD, RPT_PULSE and RPT_WAIT, and 0 otherwise.
REQ-025 All outputs SHALL be registered or decoded directly from state; there is no combinational path from Btn.
REQ-026 Parameter legality: DEB_CNT>=1, RPT_DELAY>=2, RPT_PERIOD>=2; the counter SHALL never wrap in any state.

Reset
REQ-027 Asserting Reset SHALL immediately force state=IDLE, counter=0, synchronizer flops=0, and DPB=SCEN=MCEN=CCEN=0.
REQ-028 Reset asserted mid-hold SHALL discard the held condition; after deassertion, a still-held Btn SHALL require a full new debounce and SHALL produce a new SCEN.
REQ-029 Reset deassertion SHALL take effect on the next ClkPort edge, with no pulse emitted on that edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the default DEB_CNT/RPT_DELAY/RPT_PERIOD constants; vga_top instantiates one button_conditioner per button.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff, which is reused for other asynchronous inputs.

Verification (DEB_CNT=4, RPT_DELAY=8, RPT_PERIOD=3)
REQ-032 Clean press held 10 cycles, then released -> exactly one SCEN and one MCEN pulse in the same cycle, DPB rises with them, and no repeat pulse occurs.
REQ-033 Bounce pattern 1,1,0,1,0,1,1,0 followed by 0 -> SCEN, MCEN and DPB stay 0 throughout.
REQ-034 Held for 30 cycles after PRESS_PULSE at cycle P -> MCEN at P, P+8, P+11, P+14..., CCEN continuously high, SCEN only at P.
REQ-035 Release with bounce 0,1,0,0,1,0,0,0,0 -> DPB falls only after 4 consecutive 0s, with no second SCEN.
REQ-036 Reset pulsed at P+5 while held -> all outputs 0 immediately; with Btn still high, SCEN reappears 6 edges after reset release.
REQ-037 Btn high for exactly 3 synchronized cycles -> no SCEN; exactly 4 -> one SCEN.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM encoding, default
// timing constants and small elaboration-time helpers.
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WQ_PRESS    = 3'd1,
        PRESS_PULSE = 3'd2,
        HOLD        = 3'd3,
        RPT_PULSE   = 3'd4,
        RPT_WAIT    = 3'd5,
        WQ_REL      = 3'd6
    } bc_state_t;

    typedef struct packed {
        logic dpb;
        logic scen;
        logic mcen;
        logic ccen;
    } bc_outs_t;

    // 25 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
    localparam int unsigned DEF_DEB_CNT    = 32'd2_500_000;
    localparam int unsigned DEF_RPT_DELAY  = 32'd50_000_000;
    localparam int unsigned DEF_RPT_PERIOD = 32'd10_000_000;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 32'd1);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Output levels are a pure function of the FSM state.
    function automatic bc_outs_t decode_outs(input bc_state_t s);
        bc_outs_t o;
        o = '{dpb: 1'b0, scen: 1'b0, mcen: 1'b0, ccen: 1'b0};
        case (s)
            PRESS_PULSE: o = '{dpb: 1'b1, scen: 1'b1, mcen: 1'b1, ccen: 1'b1};
            HOLD:        o = '{dpb: 1'b1, scen: 1'b0, mcen: 1'b0, ccen: 1'b1};
            RPT_PULSE:   o = '{dpb: 1'b1, scen: 1'b0, mcen: 1'b1, ccen: 1'b1};
            RPT_WAIT:    o = '{dpb: 1'b1, scen: 1'b0, mcen: 1'b0, ccen: 1'b1};
            WQ_REL:      o = '{dpb: 1'b1, scen: 1'b0, mcen: 1'b0, ccen: 1'b0};
            default:     o = '{dpb: 1'b0, scen: 1'b0, mcen: 1'b0, ccen: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reused wherever an
// external signal crosses into the ClkPort domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability filter chain
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronize, debounce press and release, and
// generate single-shot, auto-repeat and continuous enables.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CNT    = DEF_DEB_CNT,
    parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
    parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic Btn,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    localparam int unsigned CNT_MAX = max3(DEB_CNT, RPT_DELAY, RPT_PERIOD);
    localparam int unsigned CW      = cnt_width(CNT_MAX);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // The IDLE cycle that first sees the press counts as one stable sample,
    // so WQ_PRESS needs one sample fewer than DEB_CNT. Release counts only
    // zeros seen inside WQ_REL, since any bounce there restarts the count.
    localparam logic [CW-1:0] PRESS_LAST  = (DEB_CNT >= 32'd2) ? CW'(DEB_CNT - 32'd2) : CNT_ZERO;
    localparam logic [CW-1:0] REL_LAST    = CW'(DEB_CNT - 32'd1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(RPT_DELAY - 32'd2);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(RPT_PERIOD - 32'd2);

    logic      btn_s;
    bc_state_t state_r;
    bc_state_t state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    bc_outs_t  outs_r;

    sync_2ff #(.WIDTH(1)) u_sync (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .d       (Btn),
        .q       (btn_s)
    );

    // Next-state and shared counter update
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (btn_s) begin
                    state_nxt_s = WQ_PRESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WQ_PRESS: begin
                if (!btn_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == PRESS_LAST) begin
                    state_nxt_s = PRESS_PULSE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            PRESS_PULSE: begin
                state_nxt_s = HOLD;
                cnt_nxt_s   = CNT_ZERO;
            end
            HOLD: begin
                if (!btn_s) begin
                    state_nxt_s = WQ_REL;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == DELAY_LAST) begin
                    state_nxt_s = RPT_PULSE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            RPT_PULSE: begin
                state_nxt_s = RPT_WAIT;
                cnt_nxt_s   = CNT_ZERO;
            end
            RPT_WAIT: begin
                if (!btn_s) begin
                    state_nxt_s = WQ_REL;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == PERIOD_LAST) begin
                    state_nxt_s = RPT_PULSE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            WQ_REL: begin
                if (btn_s) begin
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == REL_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers; outputs track the state they
    // enter so they change on the same edge as the state itself.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            outs_r  <= '{dpb: 1'b0, scen: 1'b0, mcen: 1'b0, ccen: 1'b0};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            outs_r  <= decode_outs(state_nxt_s);
        end
    end

    assign DPB  = outs_r.dpb;
    assign SCEN = outs_r.scen;
    assign MCEN = outs_r.mcen;
    assign CCEN = outs_r.ccen;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing parameters:
// fixed vector table, directed corner sequences and randomized bouncing.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;

    logic ClkPort = 1'b0;
    logic Reset   = 1'b1;
    logic Btn     = 1'b0;
    logic DPB, SCEN, MCEN, CCEN;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: synchronizer delay line plus run-length bookkeeping
    bit m_d1, m_d2;
    int m_mode;   // 0 = not accepted, 1 = accepted and held, 2 = releasing
    int m_ones, m_zeros, m_age;
    bit m_scen, m_mcen;

    typedef struct {
        logic       btn;
        logic [3:0] exp;   // {DPB, SCEN, MCEN, CCEN}
    } vec_t;
    vec_t vecs[$];

    button_conditioner #(
        .DEB_CNT    (DEB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .Btn     (Btn),
        .DPB     (DPB),
        .SCEN    (SCEN),
        .MCEN    (MCEN),
        .CCEN    (CCEN)
    );

    always #5 ClkPort = ~ClkPort;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ages (cycles after the press pulse) at which MCEN fires
    function automatic bit is_pulse(input int a);
        return (a == 0) || (a == RD) || (a > RD && ((a - RD) % RP) == 0);
    endfunction

    task automatic model_clear();
        m_d1 = 1'b0; m_d2 = 1'b0;
        m_mode = 0; m_ones = 0; m_zeros = 0; m_age = 0;
        m_scen = 1'b0; m_mcen = 1'b0;
    endtask

    task automatic model_step();
        bit s;
        s = m_d2;
        m_d2 = m_d1;
        m_d1 = Btn;
        m_scen = 1'b0;
        m_mcen = 1'b0;
        case (m_mode)
            0: begin
                m_ones = s ? m_ones + 1 : 0;
                if (m_ones == DEB) begin
                    m_mode = 1; m_age = 0; m_ones = 0;
                    m_scen = 1'b1; m_mcen = 1'b1;
                end
            end
            1: begin
                m_age = m_age + 1;
                // the cycle right after a pulse does not look at the button
                if (!is_pulse(m_age - 1) && !s) begin
                    m_mode = 2; m_zeros = 0;
                end else if (is_pulse(m_age)) begin
                    m_mcen = 1'b1;
                end
            end
            default: begin
                m_zeros = s ? 0 : m_zeros + 1;
                if (m_zeros == DEB) begin
                    m_mode = 0; m_ones = 0;
                end
            end
        endcase
    endtask

    function automatic logic [3:0] model_out();
        return {m_mode != 0, m_scen, m_mcen, m_mode == 1};
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic tick(input logic b, output logic [3:0] o);
        Btn = b;
        @(posedge ClkPort);
        cyc++;
        if (Reset) model_clear();
        else model_step();
        #2;
        o = {DPB, SCEN, MCEN, CCEN};
        check("model", o, model_out());
    endtask

    task automatic add(input logic b, input logic [3:0] e, input int n);
        vec_t v;
        v.btn = b;
        v.exp = e;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic pulse_reset(input string name);
        Reset = 1'b1;
        #1;
        model_clear();
        check(name, {DPB, SCEN, MCEN, CCEN}, 4'b0000);
    endtask

    initial begin
        logic [3:0] o;
        logic rel_pat [9];
        logic bounce_pat [9];
        rel_pat    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bounce_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // clean press held 10 cycles, then released
        add(1'b1, 4'b0000, 5);
        add(1'b1, 4'b1111, 1);
        add(1'b1, 4'b1001, 4);
        add(1'b0, 4'b1001, 2);
        add(1'b0, 4'b1000, 4);
        add(1'b0, 4'b0000, 4);
        // bouncing press never accepted
        for (int i = 0; i < 9; i++) add(bounce_pat[i], 4'b0000, 1);
        add(1'b0, 4'b0000, 4);
        // three synchronized high cycles: rejected
        add(1'b1, 4'b0000, 3);
        add(1'b0, 4'b0000, 6);
        // four synchronized high cycles: accepted once, then released
        add(1'b1, 4'b0000, 4);
        add(1'b0, 4'b0000, 1);
        add(1'b0, 4'b1111, 1);
        add(1'b0, 4'b1001, 1);
        add(1'b0, 4'b1000, 4);
        add(1'b0, 4'b0000, 3);

        model_clear();
        repeat (3) @(posedge ClkPort);
        #2;
        check("reset_state", {DPB, SCEN, MCEN, CCEN}, 4'b0000);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0, o);

        foreach (vecs[i]) begin
            tick(vecs[i].btn, o);
            check("vector", o, vecs[i].exp);
        end

        // long hold: press pulse at t=6, repeats at +8 then every 3
        for (int t = 1; t <= 40; t++) begin
            tick(1'b1, o);
            if (t >= 6 && t <= 36) begin
                check("hold_mcen", {3'b000, MCEN}, {3'b000, is_pulse(t - 6)});
                check("hold_ccen", {3'b000, CCEN}, 4'b0001);
                check("hold_scen", {3'b000, SCEN}, {3'b000, t == 6});
            end
        end
        // bouncing release: DPB drops only after four straight zeros
        for (int t = 41; t <= 52; t++) begin
            tick((t <= 49) ? rel_pat[t - 41] : 1'b0, o);
            check("rel_scen", {3'b000, SCEN}, 4'b0000);
            if (t >= 43 && t <= 50) check("rel_dpb_held", {3'b000, DPB}, 4'b0001);
            if (t == 51) check("rel_dpb_fall", {3'b000, DPB}, 4'b0000);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, o);

        // reset while held discards the press; a fresh debounce follows
        for (int t = 1; t <= 11; t++) tick(1'b1, o);
        pulse_reset("reset_midhold");
        tick(1'b1, o);
        Reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, o);
            check("scen_after_reset", {3'b000, SCEN}, {3'b000, i == 6});
        end
        for (int i = 0; i < 8; i++) tick(1'b0, o);

        // randomized bouncing runs, long holds and occasional resets
        begin
            logic lvl;
            int   len;
            lvl = 1'b0;
            for (int r = 0; r < 600; r++) begin
                lvl = ~lvl;
                len = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
                for (int i = 0; i < len; i++) tick(lvl, o);
                if ($urandom_range(0, 49) == 0) begin
                    pulse_reset("reset_random");
                    tick(lvl, o);
                    Reset = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
